// File: rtl/tx_crc16_append_pkg.sv
// Shared CRC16 definitions for the USB transmit generator and receive checker.
// Optional build macro TX_CRC16_STALL_EN (see tx_crc16_append.sv).
package crc16_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2,
      DONE = 2'd3
   } crc16_state_e;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   // Remainder left after payload plus complemented CRC run through a fresh LFSR.
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   // One serial step, MSB-first, x^16 term implied by the shift-out of bit 15.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic        din,
                                              input logic [15:0] poly);
      logic fb;
      fb = din ^ crc[15];
      return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
   endfunction

endpackage

// File: rtl/tx_crc16_append_if.sv
// Handshake/bus bundle between the packet serializer and tx_crc16_append.
// s_en exists only when TX_CRC16_STALL_EN is defined.
interface tx_crc16_append_if;
`ifdef TX_CRC16_STALL_EN
   logic        s_en;
`endif
   logic        crc16_start;
   logic        s_in;
   logic        crc16_ack;
   logic        s_out;
   logic        out_valid;
   logic        crc16_busy;
   logic        crc16_done;
   logic [15:0] crc16_val;

   // Upstream/downstream side that drives the generator.
   modport master (
`ifdef TX_CRC16_STALL_EN
      output s_en,
`endif
      output crc16_start, s_in, crc16_ack,
      input  s_out, out_valid, crc16_busy, crc16_done, crc16_val
   );

   // The generator itself.
   modport slave (
`ifdef TX_CRC16_STALL_EN
      input  s_en,
`endif
      input  crc16_start, s_in, crc16_ack,
      output s_out, out_valid, crc16_busy, crc16_done, crc16_val
   );
endinterface

// File: rtl/tx_crc16_append_lfsr.sv
// crc16_lfsr: 16-bit serial CRC LFSR with synchronous load and enable.
// Used by both the transmit generator and the receive checker so the two
// ends run the identical algorithm.
import crc16_pkg::*;

module crc16_lfsr #(
   parameter logic [15:0] POLY = CRC16_POLY,
   parameter logic [15:0] INIT = CRC16_INIT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   assign crc_d = crc16_step(crc_q, din_i, POLY);
   assign crc_o = crc_q;

   // Seed on load, otherwise shift one bit per enabled cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)      crc_q <= INIT;
      else if (load_i) crc_q <= INIT;
      else if (en_i)   crc_q <= crc_d;
   end

endmodule

// File: rtl/tx_crc16_append.sv
// tx_crc16_append: forwards a DATA_BITS serial payload and appends the
// complemented CRC16, MSB first. Optional macro TX_CRC16_STALL_EN adds a
// bus s_en input that freezes the packet while low.
import crc16_pkg::*;

module tx_crc16_append #(
   parameter int          DATA_BITS = 64,
   parameter logic [15:0] POLY      = CRC16_POLY,
   parameter logic [15:0] INIT      = CRC16_INIT
) (
   input  logic               clk,
   input  logic               rst_n,
   tx_crc16_append_if.slave   bus
);

   localparam logic [7:0] LAST_DATA = 8'(DATA_BITS - 1);

   crc16_state_e state_q;
   logic [7:0]   cnt_q;
   logic [15:0]  val_q;
   logic         busy_q;
   logic         done_q;
   logic [15:0]  lfsr_q;
   logic [15:0]  lfsr_d;
   logic         adv;
   logic         lfsr_load;
   logic         lfsr_en;
   logic         s_out_d;
   logic         valid_d;

`ifdef TX_CRC16_STALL_EN
   assign adv = bus.s_en;
`else
   assign adv = 1'b1;
`endif

   assign lfsr_load = (state_q == IDLE) && bus.crc16_start;
   assign lfsr_en   = (state_q == DATA) && adv;
   // Value the LFSR takes after absorbing the current bit; latched on the last bit.
   assign lfsr_d    = crc16_step(lfsr_q, bus.s_in, POLY);

   crc16_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (lfsr_load),
      .en_i   (lfsr_en),
      .din_i  (bus.s_in),
      .crc_o  (lfsr_q)
   );

   // Packet sequencer: counter cleared on every state exit, stalls hold everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         val_q   <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.crc16_start) begin
               state_q <= DATA;
               cnt_q   <= 8'd0;
               busy_q  <= 1'b1;
            end
            DATA: if (adv) begin
               if (cnt_q == LAST_DATA) begin
                  val_q   <= ~lfsr_d;
                  cnt_q   <= 8'd0;
                  state_q <= CRC;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            CRC: if (adv) begin
               if (cnt_q == 8'd15) begin
                  cnt_q   <= 8'd0;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: if (bus.crc16_ack) begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 8'd0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Output mux: payload passes straight through, CRC bits come from the latch.
   always_comb begin
      s_out_d = 1'b0;
      valid_d = 1'b0;
      if (adv) begin
         case (state_q)
            DATA: begin
               s_out_d = bus.s_in;
               valid_d = 1'b1;
            end
            CRC: begin
               s_out_d = val_q[4'd15 - cnt_q[3:0]];
               valid_d = 1'b1;
            end
            default: begin
               s_out_d = 1'b0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.s_out      = s_out_d;
   assign bus.out_valid  = valid_d;
   assign bus.crc16_busy = busy_q;
   assign bus.crc16_done = done_q;
   assign bus.crc16_val  = val_q;

endmodule

// File: tb/tb_tx_crc16_append.sv
// Directed bench for tx_crc16_append (64-bit payload). A second instance seeded
// with 16'h0000 shares the stimulus for the all-zero vector. Stall vectors run
// only when TX_CRC16_STALL_EN is defined.
import crc16_pkg::*;

module tb_tx_crc16_append;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tx_crc16_append_if ifm ();
   tx_crc16_append_if if0 ();

   assign if0.crc16_start = ifm.crc16_start;
   assign if0.s_in        = ifm.s_in;
   assign if0.crc16_ack   = ifm.crc16_ack;
`ifdef TX_CRC16_STALL_EN
   assign if0.s_en        = ifm.s_en;
`endif

   tx_crc16_append #(.DATA_BITS(64)) dut (
      .clk (clk), .rst_n (rst_n), .bus (ifm.slave)
   );

   tx_crc16_append #(.DATA_BITS(64), .INIT(16'h0000)) dut0 (
      .clk (clk), .rst_n (rst_n), .bus (if0.slave)
   );

   logic        lb_load = 1'b0;
   logic        lb_en   = 1'b0;
   logic        lb_din  = 1'b0;
   logic [15:0] lb_crc;

   crc16_lfsr lb (
      .clk (clk), .rst_n (rst_n), .load_i (lb_load), .en_i (lb_en),
      .din_i (lb_din), .crc_o (lb_crc)
   );

   int vecs = 0;
   int miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         miss++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference CRC straight from the polynomial definition, MSB of payload first.
   function automatic logic [15:0] crc_model(input logic [63:0] pl, input logic [15:0] init);
      logic [15:0] r;
      logic [63:0] sh;
      logic        fb;
      r  = init;
      sh = pl;
      for (int i = 0; i < 64; i++) begin
         fb = sh[63] ^ r[15];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         sh = sh << 1;
      end
      return ~r;
   endfunction

   logic [79:0] bits, bits0;
   int          nv, nv0, cyc, zerr, verr;
   bit          done_seen, aborted, last_st;

   // Start one packet and collect valid output bits until done (or abort).
   task automatic run_pkt(input logic [63:0] pl, input int stall_pct,
                          input int rst_at, input bit poke_start);
      logic [63:0] sh;
      nv = 0; nv0 = 0; zerr = 0; verr = 0;
      done_seen = 0; aborted = 0; last_st = 0;
      bits = '0; bits0 = '0;
      ifm.crc16_ack   = 1'b0;
      ifm.crc16_start = 1'b1;
      @(negedge clk);
      ifm.crc16_start = 1'b0;
      cyc = 1;
      while (cyc < 300) begin
         sh = pl << nv;
         ifm.s_in = (nv < 64) ? sh[63] : 1'($urandom);
         ifm.crc16_start = poke_start && (cyc == 20);
`ifdef TX_CRC16_STALL_EN
         ifm.s_en = ($urandom_range(99) >= stall_pct);
         if (stall_pct > 0 && nv == 79 && !last_st) begin
            ifm.s_en = 1'b0;
            last_st  = 1;
         end
`endif
         if (rst_at >= 0 && nv == rst_at) begin
            rst_n = 1'b0;
            ifm.crc16_start = 1'b0;
            @(negedge clk);
            aborted = 1;
            break;
         end
         #1;
         if (!ifm.out_valid && ifm.s_out) zerr++;
`ifdef TX_CRC16_STALL_EN
         if (!ifm.s_en && ifm.out_valid) verr++;
`endif
         if (ifm.crc16_done) begin
            done_seen = 1;
            break;
         end
         if (ifm.out_valid) begin
            bits = {bits[78:0], ifm.s_out};
            nv++;
         end
         if (if0.out_valid) begin
            bits0 = {bits0[78:0], if0.s_out};
            nv0++;
         end
         @(negedge clk);
         cyc++;
      end
      ifm.crc16_start = 1'b0;
   endtask

   // Push payload plus emitted CRC through a fresh LFSR; DUT idles in DONE meanwhile.
   task automatic loopback(input logic [79:0] b, output logic [15:0] rem);
      logic [79:0] sh;
      sh = b;
      @(negedge clk);
      lb_load = 1'b1;
      @(negedge clk);
      lb_load = 1'b0;
      for (int i = 0; i < 80; i++) begin
         lb_en  = 1'b1;
         lb_din = sh[79];
         sh     = sh << 1;
         @(negedge clk);
      end
      lb_en = 1'b0;
      #1;
      rem = lb_crc;
   endtask

   task automatic do_ack(input string tag);
      ifm.crc16_ack = 1'b1;
      @(negedge clk);
      ifm.crc16_ack = 1'b0;
      #1;
      chk({tag, "_done_clr"}, 32'(ifm.crc16_done), 32'd0);
   endtask

   // Full check of a completed default-seed packet.
   task automatic check_pkt(input string tag, input logic [63:0] pl);
      logic [15:0] rem, held;
      chk({tag, "_done"},  32'(done_seen), 32'd1);
      chk({tag, "_nbits"}, 32'(nv), 32'd80);
      chk({tag, "_val"},   32'(ifm.crc16_val), 32'(crc_model(pl, 16'hFFFF)));
      chk({tag, "_pay"},   32'(bits[79:16] == pl), 32'd1);
      chk({tag, "_crcbits"}, 32'(bits[15:0]), 32'(crc_model(pl, 16'hFFFF)));
      chk({tag, "_zero"},  32'(zerr), 32'd0);
      held = ifm.crc16_val;
      loopback(bits, rem);
      chk({tag, "_resid"}, 32'(rem), 32'(CRC16_RESIDUAL));
      chk({tag, "_held"},  32'(ifm.crc16_done), 32'd1);
      chk({tag, "_stable"}, 32'(ifm.crc16_val), 32'(held));
   endtask

   logic [63:0] pl_a, pl_b;
`ifdef TX_CRC16_STALL_EN
   logic [79:0] ref_bits;
`endif

   initial begin
      ifm.crc16_start = 1'b0;
      ifm.s_in        = 1'b0;
      ifm.crc16_ack   = 1'b0;
`ifdef TX_CRC16_STALL_EN
      ifm.s_en        = 1'b1;
`endif
      repeat (3) @(negedge clk);
      #1;
      chk("rst_valid", 32'(ifm.out_valid), 32'd0);
      chk("rst_sout",  32'(ifm.s_out), 32'd0);
      chk("rst_busy",  32'(ifm.crc16_busy), 32'd0);
      chk("rst_done",  32'(ifm.crc16_done), 32'd0);
      chk("rst_val",   32'(ifm.crc16_val), 32'd0);
      chk("rst_val0",  32'(if0.crc16_val), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // All-zero payload: zero seed gives FFFF, done 81 cycles after start.
      run_pkt(64'h0, 0, -1, 0);
      chk("z_cyc",   32'(cyc), 32'd81);
      chk("z_val0",  32'(if0.crc16_val), 32'hFFFF);
      chk("z_nv0",   32'(nv0), 32'd80);
      chk("z_pay0",  32'(bits0[79:16] == 64'h0), 32'd1);
      chk("z_crc0",  32'(bits0[15:0]), 32'hFFFF);
      check_pkt("z", 64'h0);
      do_ack("z");

      // Random payload with a stray start mid-payload, then start+ack together.
      pl_a = {$urandom, $urandom};
      run_pkt(pl_a, 0, -1, 1);
      chk("p_cyc", 32'(cyc), 32'd81);
      check_pkt("p", pl_a);
      ifm.crc16_ack   = 1'b1;
      ifm.crc16_start = 1'b1;
      @(negedge clk);
      ifm.crc16_ack   = 1'b0;
      ifm.crc16_start = 1'b0;
      #1;
      chk("sa_done", 32'(ifm.crc16_done), 32'd0);
      chk("sa_busy", 32'(ifm.crc16_busy), 32'd0);
      @(negedge clk);
      #1;
      chk("sa_idle_busy",  32'(ifm.crc16_busy), 32'd0);
      chk("sa_idle_valid", 32'(ifm.out_valid), 32'd0);

      // Reset while bit 30 of the payload is on the wire.
      run_pkt({$urandom, $urandom}, 0, 30, 0);
      #1;
      chk("ab_hit",   32'(aborted), 32'd1);
      chk("ab_valid", 32'(ifm.out_valid), 32'd0);
      chk("ab_busy",  32'(ifm.crc16_busy), 32'd0);
      chk("ab_done",  32'(ifm.crc16_done), 32'd0);
      chk("ab_val",   32'(ifm.crc16_val), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      pl_b = {$urandom, $urandom};
      run_pkt(pl_b, 0, -1, 0);
      chk("r_cyc", 32'(cyc), 32'd81);
      check_pkt("r", pl_b);
      do_ack("r");

`ifdef TX_CRC16_STALL_EN
      // Same payload without and with random stalls must give identical bits.
      pl_a = {$urandom, $urandom};
      run_pkt(pl_a, 0, -1, 0);
      ref_bits = bits;
      check_pkt("ns", pl_a);
      do_ack("ns");
      run_pkt(pl_a, 35, -1, 0);
      chk("st_lastcrc", 32'(last_st), 32'd1);
      chk("st_vld_low", 32'(verr), 32'd0);
      chk("st_bits_hi", 32'(bits[79:48]), 32'(ref_bits[79:48]));
      chk("st_bits_md", 32'(bits[47:16]), 32'(ref_bits[47:16]));
      chk("st_bits_lo", 32'(bits[15:0]),  32'(ref_bits[15:0]));
      check_pkt("st", pl_a);
      do_ack("st");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
